// File: rtl/axis_out_packer_if.sv
// axis_out_packer_if: result-beat input stream and packed AXI-Stream output of axis_out_packer
interface axis_out_packer_if #(
  parameter int ROWS      = 4,
  parameter int Y_BITS    = 24,
  parameter int AXI_WIDTH = 256,
  parameter int W_BPT     = 8
);
  logic                   s_valid;
  logic                   s_ready;
  logic [ROWS*Y_BITS-1:0] s_data;
  logic                   s_last;
  logic [W_BPT-1:0]       s_bpt;
  logic                   s_relu;
  logic                   m_axis_tready;
  logic                   m_axis_tvalid;
  logic [AXI_WIDTH-1:0]   m_axis_tdata;
  logic [AXI_WIDTH/8-1:0] m_axis_tkeep;
  logic                   m_axis_tlast;
  logic [W_BPT-1:0]       m_axis_tuser;
  modport slave (
    input  s_valid, s_data, s_last, s_bpt, s_relu, m_axis_tready,
    output s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
  );
  modport master (
    output s_valid, s_data, s_last, s_bpt, s_relu, m_axis_tready,
    input  s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/axis_out_packer.sv
// axis_out_packer: converts signed lanes to Y_OUT_BITS (extend/saturate) and packs slots into AXI beats; OUT_PACKER_RELU_EN adds ReLU
module axis_out_packer #(
  parameter int ROWS       = 4,
  parameter int Y_BITS     = 24,
  parameter int Y_OUT_BITS = 16,
  parameter int AXI_WIDTH  = 256,
  parameter int W_BPT      = 8
) (
  input logic aclk,
  input logic aresetn,
  axis_out_packer_if.slave bus
);
  localparam int SLOT_W = ROWS * Y_OUT_BITS;
  localparam int P      = AXI_WIDTH / SLOT_W;
  localparam int CW     = P > 1 ? $clog2(P) : 1;
  localparam int KW     = AXI_WIDTH / 8;
  localparam int SB     = SLOT_W / 8;
  logic [SLOT_W-1:0]    slot;
  logic [AXI_WIDTH-1:0] acc;
  logic [AXI_WIDTH-1:0] merged;
  logic [KW-1:0]        keep;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 done;
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [Y_BITS-1:0] y_in;
    logic [Y_BITS-1:0] y;
    assign y_in = bus.s_data[i*Y_BITS +: Y_BITS];
`ifdef OUT_PACKER_RELU_EN
    assign y = (bus.s_relu && y_in[Y_BITS-1]) ? '0 : y_in;
`else
    assign y = y_in;
`endif
    if (Y_OUT_BITS > Y_BITS) begin : g_ext
      assign slot[i*Y_OUT_BITS +: Y_OUT_BITS] = {{(Y_OUT_BITS-Y_BITS){y[Y_BITS-1]}}, y};
    end else if (Y_OUT_BITS == Y_BITS) begin : g_eq
      assign slot[i*Y_OUT_BITS +: Y_OUT_BITS] = y;
    end else begin : g_sat
      logic fits;
      assign fits = y[Y_BITS-1:Y_OUT_BITS-1] == {(Y_BITS-Y_OUT_BITS+1){y[Y_BITS-1]}};
      assign slot[i*Y_OUT_BITS +: Y_OUT_BITS] = fits ? y[Y_OUT_BITS-1:0]
                                                     : {y[Y_BITS-1], {(Y_OUT_BITS-1){~y[Y_BITS-1]}}};
    end
  end
`ifndef OUT_PACKER_RELU_EN
  logic unused_relu;
  assign unused_relu = bus.s_relu;
`endif
  assign bus.s_ready = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign accept      = bus.s_valid && bus.s_ready;
  assign done        = accept && (cnt == CW'(P - 1) || bus.s_last);
  assign merged      = acc | (AXI_WIDTH'(slot) << (SLOT_W * int'(cnt)));
  assign keep        = ~({KW{1'b1}} << (SB * (int'(cnt) + 1)));
  // slot counter and partially packed beat; cleared whenever a beat is handed to the output
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cnt <= '0;
      acc <= '0;
    end else if (done) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      acc <= merged;
    end
  // output register: reloads on a completing accept (even while draining), else drops valid on handshake
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tuser  <= '0;
    end else if (done) begin
      bus.m_axis_tvalid <= 1'b1;
      bus.m_axis_tdata  <= merged;
      bus.m_axis_tkeep  <= keep;
      bus.m_axis_tlast  <= bus.s_last;
      bus.m_axis_tuser  <= bus.s_bpt;
    end else if (bus.m_axis_tready) begin
      bus.m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axis_out_packer.sv
// tb_axis_out_packer: directed and scoreboarded checks of axis_out_packer (default and widening configs)
module tb_axis_out_packer;
  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [7:0]   u;
  } beat_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic thr = 1'b0;
  logic drop = 1'b0;
  logic [255:0] m_acc = '0;
  int m_cnt = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  always #5 aclk = ~aclk;
  axis_out_packer_if #(.ROWS(4), .Y_BITS(24), .AXI_WIDTH(256), .W_BPT(8)) dif ();
  axis_out_packer_if #(.ROWS(4), .Y_BITS(24), .AXI_WIDTH(256), .W_BPT(8)) wif ();
  axis_out_packer #(.ROWS(4), .Y_BITS(24), .Y_OUT_BITS(16), .AXI_WIDTH(256), .W_BPT(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(dif)
  );
  axis_out_packer #(.ROWS(4), .Y_BITS(24), .Y_OUT_BITS(32), .AXI_WIDTH(256), .W_BPT(8)) dut_w (
    .aclk(aclk), .aresetn(aresetn), .bus(wif)
  );
  // cycle counter for throughput measurement
  always @(posedge aclk) cyc <= cyc + 1;
  // record every output handshake, sampled mid-cycle
  always @(negedge aclk) begin
    beat_t b;
    #2;
    if (thr && !dif.s_ready) drop = 1'b1;
    if (dif.m_axis_tvalid && dif.m_axis_tready) begin
      b.d = dif.m_axis_tdata;
      b.k = dif.m_axis_tkeep;
      b.l = dif.m_axis_tlast;
      b.u = dif.m_axis_tuser;
      obs_q.push_back(b);
    end
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] sat16(input logic [23:0] v);
    int s;
    s = $signed(v);
    return s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
  endfunction
  task automatic model(input logic [95:0] d, input logic last, input logic [7:0] bpt);
    beat_t e;
    for (int i = 0; i < 4; i++) m_acc[m_cnt*64 + i*16 +: 16] = sat16(d[i*24 +: 24]);
    m_cnt++;
    if (last || m_cnt == 4) begin
      e.d = m_acc;
      e.k = 32'hFFFF_FFFF >> (32 - 8*m_cnt);
      e.l = last;
      e.u = bpt;
      exp_q.push_back(e);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask
  task automatic send(input logic [95:0] d, input logic last, input logic [7:0] bpt);
    int t;
    t = 0;
    dif.s_valid = 1'b1;
    dif.s_data = d;
    dif.s_last = last;
    dif.s_bpt = bpt;
    #1;
    while (!dif.s_ready && t < 50) begin
      @(negedge aclk);
      #1;
      t++;
    end
    if (t == 50) chk("send_stall", dif.s_ready, 1);
    @(negedge aclk);
    dif.s_valid = 1'b0;
    model(d, last, bpt);
  endtask
  task automatic get_beat(output beat_t b);
    int t;
    t = 0;
    b = '0;
    while (obs_q.size() == 0 && t < 50) begin
      @(negedge aclk);
      t++;
    end
    if (obs_q.size() == 0) chk("beat_timeout", obs_q.size(), 1);
    else b = obs_q.pop_front();
  endtask
  task automatic check_beat(input string tag, input beat_t b, input logic [255:0] d,
                            input logic [31:0] k, input logic l, input logic [7:0] u);
    chk({tag, "_data"}, b.d, d);
    chk({tag, "_keep"}, b.k, k);
    chk({tag, "_last"}, b.l, l);
    chk({tag, "_user"}, b.u, u);
  endtask
  task automatic score(input string tag);
    beat_t b;
    beat_t e;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      b = obs_q.pop_front();
      e = exp_q.pop_front();
      check_beat(tag, b, e.d, e.k, e.l, e.u);
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    beat_t b;
    logic [95:0] d;
    logic [255:0] snap;
    int t;
    int c0;
    dif.s_valid = 0; dif.s_data = '0; dif.s_last = 0; dif.s_bpt = '0; dif.s_relu = 0;
    dif.m_axis_tready = 1;
    wif.s_valid = 0; wif.s_data = '0; wif.s_last = 0; wif.s_bpt = '0; wif.s_relu = 0;
    wif.m_axis_tready = 1;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", dif.m_axis_tvalid, 0);
    chk("rst_tdata", dif.m_axis_tdata, 0);
    chk("rst_tkeep", dif.m_axis_tkeep, 0);
    chk("rst_tlast", dif.m_axis_tlast, 0);
    chk("rst_tuser", dif.m_axis_tuser, 0);
    chk("rst_sready", dif.s_ready, 1);
    aresetn = 1'b1;
    @(negedge aclk);
    send({4{24'h000010}}, 0, 8'h01);
    send({4{24'h7FFFFF}}, 0, 8'h02);
    send({4{24'h800000}}, 0, 8'h03);
    send({4{24'hFFFFFF}}, 1, 8'h04);
    get_beat(b);
    check_beat("satpack", b, {{4{16'hFFFF}}, {4{16'h8000}}, {4{16'h7FFF}}, {4{16'h0010}}},
               32'hFFFF_FFFF, 1, 8'h04);
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 4; i++) d[i*24 +: 24] = 24'(j*256 + i);
      send(d, j == 5, 8'(8'h10 + j));
    end
    get_beat(b);
    check_beat("six_b1", b, {64'h0303_0302_0301_0300, 64'h0203_0202_0201_0200,
                             64'h0103_0102_0101_0100, 64'h0003_0002_0001_0000},
               32'hFFFF_FFFF, 0, 8'h13);
    get_beat(b);
    check_beat("six_b2", b, {128'h0, 64'h0503_0502_0501_0500, 64'h0403_0402_0401_0400},
               32'h0000_FFFF, 1, 8'h15);
    send({24'hFF8000, 24'h007FFF, 24'h008000, 24'hFF7FFF}, 1, 8'h2A);
    get_beat(b);
    check_beat("one_slot", b, {192'h0, 64'h8000_7FFF_7FFF_8000}, 32'h0000_00FF, 1, 8'h2A);
    dif.s_relu = 1'b1;
    send({24'h800000, 24'hFFFFF0, 24'h000020, 24'hFFFFF0}, 1, 8'h33);
    dif.s_relu = 1'b0;
    get_beat(b);
`ifdef OUT_PACKER_RELU_EN
    check_beat("relu", b, {192'h0, 64'h0000_0000_0020_0000}, 32'h0000_00FF, 1, 8'h33);
`else
    check_beat("relu_off", b, {192'h0, 64'h8000_FFF0_0020_FFF0}, 32'h0000_00FF, 1, 8'h33);
`endif
    obs_q.delete();
    exp_q.delete();
    dif.m_axis_tready = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++)
          send({24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)},
               n == 15 || $urandom_range(0, 4) == 0, 8'($urandom));
      end
      begin
        t = 0;
        do begin
          @(negedge aclk);
          #1;
          t++;
        end while (!dif.m_axis_tvalid && t < 100);
        chk("bp_tvalid", dif.m_axis_tvalid, 1);
        snap = dif.m_axis_tdata;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          #1;
          chk("bp_sready", dif.s_ready, 0);
          chk("bp_hold_valid", dif.m_axis_tvalid, 1);
          chk("bp_hold_data", dif.m_axis_tdata, snap);
        end
        @(negedge aclk);
        dif.m_axis_tready = 1'b1;
      end
    join
    repeat (4) @(negedge aclk);
    score("bp");
    thr = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 64; n++)
      send({24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)}, n == 63, 8'($urandom));
    chk("thr_cycles", cyc - c0, 64);
    thr = 1'b0;
    chk("thr_no_drop", drop, 0);
    repeat (3) @(negedge aclk);
    chk("thr_beats", obs_q.size(), 16);
    score("thr");
    send({4{24'h000ABC}}, 0, 8'h50);
    send({4{24'h000ABC}}, 0, 8'h51);
    send({4{24'h000ABC}}, 0, 8'h52);
    send({4{24'h000ABC}}, 1, 8'h5A);
    get_beat(b);
    send({4{24'h000999}}, 0, 8'h60);
    send({4{24'h000999}}, 0, 8'h61);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", dif.m_axis_tvalid, 0);
    chk("mid_rst_tdata", dif.m_axis_tdata, 0);
    chk("mid_rst_tkeep", dif.m_axis_tkeep, 0);
    chk("mid_rst_tlast", dif.m_axis_tlast, 0);
    chk("mid_rst_tuser", dif.m_axis_tuser, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_acc = '0;
    m_cnt = 0;
    obs_q.delete();
    send({4{24'h001111}}, 0, 8'h70);
    send({4{24'h002222}}, 0, 8'h71);
    send({4{24'h003333}}, 0, 8'h72);
    send({4{24'h004444}}, 1, 8'h77);
    get_beat(b);
    check_beat("post_rst", b, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
               32'hFFFF_FFFF, 1, 8'h77);
    repeat (3) @(negedge aclk);
    chk("post_rst_extra", obs_q.size(), 0);
    exp_q.delete();
    wif.s_data = {24'h000005, 24'h800000, 24'h000005, 24'h800000};
    wif.s_last = 1'b1;
    wif.s_bpt = 8'h09;
    wif.s_valid = 1'b1;
    @(negedge aclk);
    wif.s_valid = 1'b0;
    #1;
    chk("wide_tvalid", wif.m_axis_tvalid, 1);
    chk("wide_tdata", wif.m_axis_tdata,
        {128'h0, 32'h0000_0005, 32'hFF80_0000, 32'h0000_0005, 32'hFF80_0000});
    chk("wide_tkeep", wif.m_axis_tkeep, 32'h0000_FFFF);
    chk("wide_tlast", wif.m_axis_tlast, 1);
    chk("wide_tuser", wif.m_axis_tuser, 8'h09);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_out_packer.md
Name: axis_out_packer

Overview:
- Output-side stage between the processing engine and the output DMA stream.
- Converts each Y_BITS signed lane of a ROWS-wide result beat to Y_OUT_BITS:
  - sign-extends when widening;
  - saturates when narrowing.
- Packs P = AXI_WIDTH/(ROWS*Y_OUT_BITS) converted beats into one AXI beat, with per-byte tkeep on partial final beats.
- Carries the bytes-per-transfer sideband, generalising the fixed sign-pad + width-adapter path.

Parameters:
- ROWS, 4, lanes per input beat
- Y_BITS, 24, input lane width (signed)
- Y_OUT_BITS, 16, output lane width (signed); multiple of 8
- AXI_WIDTH, 256, output data width; must be a multiple of ROWS*Y_OUT_BITS
- W_BPT, 8, bytes-per-transfer sideband width
- SLOT_W, ROWS*Y_OUT_BITS (derived), slot width
- P, AXI_WIDTH/SLOT_W (derived), slots per output beat

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat ready
- s_data  in  ROWS*Y_BITS  lanes; lane i at [Y_BITS*(i+1)-1 : Y_BITS*i]
- s_last  in  1  last beat of packet
- s_bpt  in  W_BPT  bytes-per-transfer for this beat
- s_relu  in  1  ReLU enable (only used when the feature is compiled in)
- m_axis_tready  in  1
- m_axis_tvalid  out  1
- m_axis_tdata  out  AXI_WIDTH
- m_axis_tkeep  out  AXI_WIDTH/8
- m_axis_tlast  out  1
- m_axis_tuser  out  W_BPT  bytes-per-transfer

Behaviour:
- Clock and reset: single clock aclk. Reset is asynchronous and active-low (aresetn).
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, slot count cnt=0, accumulator=0.
- s_ready = !m_axis_tvalid || m_axis_tready. This is combinational and independent of s_valid/s_last.
- Lane conversion (combinational on s_data):
  - Y_OUT_BITS >= Y_BITS: sign-extend.
  - Otherwise: clamp to [-2^(Y_OUT_BITS-1), 2^(Y_OUT_BITS-1)-1], then take the low Y_OUT_BITS bits.
- Accept (s_valid && s_ready):
  - Converted slot is written to accumulator bits [SLOT_W*(cnt+1)-1 : SLOT_W*cnt].
  - Completing accept: cnt==P-1 or s_last=1.
    - Assembled beat, including the new slot, loads the output register on the same edge.
    - m_axis_tvalid←1.
    - m_axis_tkeep← low (cnt+1)*SLOT_W/8 bits set, rest 0.
    - m_axis_tlast←s_last; m_axis_tuser←s_bpt.
    - Unfilled slots of m_axis_tdata are 0.
    - cnt←0; accumulator cleared.
  - Non-completing accept: cnt←cnt+1.
- Latency: 1 cycle from the completing accept to m_axis_tvalid.
- Output handshake: m_axis_tvalid && m_axis_tready with no completing accept on the same edge → m_axis_tvalid←0.
  - Output register contents are held stable while m_axis_tvalid && !m_axis_tready.
- Simultaneous drain and completing accept: the output register reloads, m_axis_tvalid stays 1. Full throughput is one input beat per cycle.
- P=1: every accept completes; the block acts as a converting register slice.
- s_last on slot 0: one-slot beat, tkeep has SLOT_W/8 bits set.
- cnt is a $clog2(P)-bit counter (min 1 bit) and never exceeds P-1; no wrap past P-1.
- Reset mid-packet: partially packed slots are discarded and cnt returns to 0. Upstream restarts the packet.

Optional Feature:
- Macro: OUT_PACKER_RELU_EN.
- Defined: when s_relu=1 on an accepted beat, negative input lanes become 0 before saturation/extension. When s_relu=0, no change.
- Undefined: s_relu is ignored; no ReLU logic is synthesised.

Test Plan:
- Widening config (Y_BITS=24, Y_OUT_BITS=32, ROWS=4, AXI_WIDTH=256, P=2): lane 0x800000 → 0xFF800000; lane 0x000005 → 0x00000005.
- Default config, tready=1: beats with lanes 0x000010, 0x7FFFFF, 0x800000, 0xFFFFFF, s_last on 4th beat:
  - one output beat, tkeep all ones, tlast=1;
  - lanes 0x0010, 0x7FFF, 0x8000, 0xFFFF.
  - Tests saturation, pack order and tlast.
- Default config: 6 beats with s_last on 6th → beat 1 full; beat 2 tkeep=0x0000FFFF, upper 128 data bits 0, tlast=1, tuser = s_bpt of 6th beat.
- Backpressure: hold tready=0 for 5 cycles after the first completed beat:
  - s_ready=0 during the hold;
  - output stable;
  - after release no beat is lost or duplicated across 16 random beats.
- Throughput: tready=1 and continuous s_valid for 64 beats → 16 output beats on 16 consecutive-capable slots; s_ready never drops.
- Reset: assert aresetn=0 after 2 of 4 slots → all outputs 0. A subsequent 4-beat packet produces exactly one beat with only the new data.
- With OUT_PACKER_RELU_EN: s_relu=1, lane 0xFFFFF0 → output lane 0x0000.
